// File: rtl/gray_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : gray_seq_decoder
// Purpose  : Samples a W-bit gray-coded bus, decodes it to binary, classifies
//            each valid transition (HOLD / UP / DN / ILLEGAL), tracks a
//            position count and runs an IDLE/ACQ/LOCKED/ERR protocol checker.
// Options  : ERR_CNT_EN - when defined, builds a saturating 8-bit counter of
//            illegal transitions (cleared by reset only); otherwise err_count
//            is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module gray_seq_decoder #(
  parameter int W        = 2,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     gray_in,
  input  logic             in_valid,
  input  logic             clr,
  output logic [W-1:0]     bin_out,
  output logic             step_up,
  output logic             step_dn,
  output logic [CNT_W-1:0] pos_cnt,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  localparam logic [W-1:0]     W_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     W_ALL1  = {W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       LOCK_C  = 8'(LOCK_CNT);

  state_t         state;
  state_t         nxt_state;
  logic [7:0]     run;
  logic [7:0]     nxt_run;
  logic [7:0]     run_inc;
  logic [W-1:0]   prev_bin;
  logic [W-1:0]   bin;
  logic [W-1:0]   delta;
  logic           is_hold;
  logic           is_up;
  logic           is_dn;
  logic           is_ill;
  logic           sample;

  // Each binary bit is the XOR of all gray bits at or above it; this avoids a
  // bit-to-bit ripple chain inside one vector.
  for (genvar gi = 0; gi < W; gi++) begin : g_dec
    assign bin[gi] = ^gray_in[W-1:gi];
  end

  // clr always wins over a coincident sample.
  assign sample  = in_valid & ~clr;
  assign delta   = bin - prev_bin;
  assign is_hold = (delta == '0);
  assign is_up   = (delta == W_ONE);
  assign is_dn   = (delta == W_ALL1);
  assign is_ill  = ~(is_hold | is_up | is_dn);
  assign run_inc = run + 8'd1;

  // Next-state and up-step run length for the acquisition FSM.
  always_comb begin
    nxt_state = state;
    nxt_run   = run;
    if (clr) begin
      nxt_state = S_IDLE;
      nxt_run   = 8'd0;
    end else if (in_valid) begin
      case (state)
        S_IDLE: begin
          nxt_state = S_ACQ;
          nxt_run   = 8'd0;
        end
        S_ACQ: begin
          if (is_up) begin
            nxt_run = run_inc;
            if (run_inc >= LOCK_C) nxt_state = S_LOCKED;
          end else if (is_dn) begin
            nxt_run = 8'd0;
          end else if (is_ill) begin
            nxt_state = S_ERR;
          end
        end
        S_LOCKED: begin
          if (is_dn || is_ill) nxt_state = S_ERR;
        end
        default: nxt_state = S_ERR;  // ERR is held until clr
      endcase
    end
  end

  // FSM state, datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      run      <= 8'd0;
      prev_bin <= '0;
      bin_out  <= '0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      pos_cnt  <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= nxt_state;
      run     <= nxt_run;
      locked  <= (nxt_state == S_LOCKED);
      err     <= (nxt_state == S_ERR);
      step_up <= 1'b0;
      step_dn <= 1'b0;
      if (sample) begin
        prev_bin <= bin;
        bin_out  <= bin;
        if (state == S_IDLE) begin
          // First sample only establishes the reference position.
          pos_cnt <= '0;
        end else begin
          step_up <= is_up;
          step_dn <= is_dn;
          if (is_up)      pos_cnt <= pos_cnt + CNT_ONE;
          else if (is_dn) pos_cnt <= pos_cnt - CNT_ONE;
        end
      end
    end
  end

`ifdef ERR_CNT_EN
  // Saturating count of illegal transitions; survives clr, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (sample && (state != S_IDLE) && is_ill && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_seq_decoder
// Purpose  : Self-checking bench for gray_seq_decoder: integer-level reference
//            model, per-cycle comparison on the falling edge, directed
//            scenarios with literal expectations, then randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_seq_decoder;

  localparam int W        = 2;
  localparam int LOCK_CNT = 4;
  localparam int CNT_W    = 8;
  localparam int NB       = 1 << W;
  localparam int NP       = 1 << CNT_W;

  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;
  localparam int M_ERR    = 3;

`ifdef ERR_CNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [W-1:0]     gray_in;
  logic             in_valid;
  logic             clr;
  logic [W-1:0]     bin_out;
  logic             step_up;
  logic             step_dn;
  logic [CNT_W-1:0] pos_cnt;
  logic             locked;
  logic             err;
  logic [7:0]       err_count;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  // reference model state
  int m_state, m_prev, m_run, m_bin, m_pos, m_errc;
  bit m_up, m_dn;

  gray_seq_decoder #(.W(W), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .in_valid  (in_valid),
    .clr       (clr),
    .bin_out   (bin_out),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .pos_cnt   (pos_cnt),
    .locked    (locked),
    .err       (err),
    .err_count (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Binary value whose gray code equals g, found by searching all codes.
  function automatic int g2b(input int g);
    for (int k = 0; k < NB; k++) if ((k ^ (k >> 1)) == g) return k;
    return -1;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_prev = 0; m_run = 0; m_bin = 0;
    m_pos = 0; m_errc = 0; m_up = 0; m_dn = 0;
  endtask

  task automatic model_step(input bit v, input int g, input bit c);
    int b, d;
    bit ill;
    m_up = 0; m_dn = 0;
    if (!rst_n) begin model_reset(); return; end
    if (c) begin m_state = M_IDLE; m_run = 0; return; end
    if (!v) return;
    b = g2b(g);
    if (m_state == M_IDLE) begin
      m_prev = b; m_bin = b; m_pos = 0; m_run = 0; m_state = M_ACQ;
      return;
    end
    d = (b - m_prev + NB) % NB;
    m_prev = b; m_bin = b;
    ill = (d != 0) && (d != 1) && (d != NB - 1);
    if (d == 1) begin m_up = 1; m_pos = (m_pos + 1) % NP; end
    else if (d == NB - 1) begin m_dn = 1; m_pos = (m_pos + NP - 1) % NP; end
    if (ill && ERRCNT_ON && m_errc < 255) m_errc++;
    if (m_state == M_ACQ) begin
      if (d == 1) begin
        m_run++;
        if (m_run >= LOCK_CNT) m_state = M_LOCKED;
      end else if (d == NB - 1) m_run = 0;
      else if (ill) m_state = M_ERR;
    end else if (m_state == M_LOCKED) begin
      if (d == NB - 1 || ill) m_state = M_ERR;
    end
  endtask

  // Drive one cycle of inputs, then advance the model past the clock edge.
  task automatic apply(input bit v, input logic [W-1:0] g, input bit c);
    in_valid = v; gray_in = g; clr = c;
    @(posedge clk);
    model_step(v, int'(g), c);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        vectors++;
        if (bin_out !== W'(m_bin) || step_up !== m_up || step_dn !== m_dn ||
            pos_cnt !== CNT_W'(m_pos) || locked !== (m_state == M_LOCKED) ||
            err !== (m_state == M_ERR) || err_count !== 8'(m_errc)) begin
          miscompares++;
          $display("FAIL cycle t=%0t bin_out=%0d/%0d up=%0b/%0b dn=%0b/%0b pos=%0d/%0d lock=%0b/%0b err=%0b/%0b errc=%0d/%0d",
                   $time, bin_out, m_bin, step_up, m_up, step_dn, m_dn, pos_cnt, m_pos,
                   locked, (m_state == M_LOCKED), err, (m_state == M_ERR), err_count, m_errc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ups;
    int b, sel;
    bit v, c;
    int exp_bin[5];
    int seq_g[5];
    exp_bin = '{0, 1, 2, 3, 0};
    seq_g   = '{0, 1, 3, 2, 0};

    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; gray_in = '0;
    model_reset();
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    #1;
    check_lit("reset_bin_out", bin_out, 0);
    check_lit("reset_pos_cnt", pos_cnt, 0);
    check_lit("reset_flags", {locked, err, step_up, step_dn}, 0);
    check_lit("reset_err_count", err_count, 0);

    // Clean incrementing sequence reaches lock after LOCK_CNT up-steps.
    ups = 0;
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, W'(seq_g[i]), 1'b0);
      check_lit("seq_bin_out", bin_out, exp_bin[i]);
      ups += int'(step_up);
      if (i == 3) check_lit("not_yet_locked", locked, 0);
    end
    check_lit("seq_up_pulses", ups, 4);
    check_lit("seq_pos_cnt", pos_cnt, 4);
    check_lit("seq_locked", locked, 1);

    // Backward step while locked: counted down, then error.
    apply(1'b1, 2'd0, 1'b0);
    apply(1'b1, 2'd2, 1'b0);
    check_lit("dn_pulse", step_dn, 1);
    check_lit("dn_pos_cnt", pos_cnt, 3);
    check_lit("dn_err", err, 1);
    check_lit("dn_locked", locked, 0);
    apply(1'b0, 2'd0, 1'b1);
    check_lit("clr_err", err, 0);

    // Illegal jump during acquisition.
    apply(1'b1, 2'd0, 1'b0);
    apply(1'b1, 2'd3, 1'b0);
    check_lit("ill_err", err, 1);
    check_lit("ill_no_step", {step_up, step_dn}, 0);
    check_lit("ill_bin_out", bin_out, 2);
    check_lit("ill_err_count", err_count, ERRCNT_ON ? 1 : 0);
    for (int i = 0; i < 300; i++) apply(1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, 1'b0);
    check_lit("errcnt_saturate", err_count, ERRCNT_ON ? 255 : 0);
    apply(1'b0, 2'd0, 1'b1);
    check_lit("errcnt_survives_clr", err_count, ERRCNT_ON ? 255 : 0);

    // Holds and valid gaps leave run and position alone.
    apply(1'b1, 2'd0, 1'b0);
    apply(1'b0, 2'd3, 1'b0);
    apply(1'b1, 2'd1, 1'b0);
    apply(1'b0, 2'd2, 1'b0);
    check_lit("gap_no_pulse", step_up, 0);
    apply(1'b1, 2'd1, 1'b0);
    apply(1'b1, 2'd1, 1'b0);
    check_lit("hold_pos_cnt", pos_cnt, 1);
    apply(1'b0, 2'd0, 1'b0);
    apply(1'b1, 2'd3, 1'b0);
    check_lit("hold_then_up", step_up, 1);
    check_lit("hold_pos_final", pos_cnt, 2);

    // clr with a coincident sample: sample ignored, FSM back to IDLE.
    apply(1'b1, 2'd1, 1'b1);
    check_lit("clr_valid_bin_out", bin_out, 2);
    check_lit("clr_valid_flags", {locked, err}, 0);
    apply(1'b1, 2'd3, 1'b0);
    check_lit("after_clr_first_sample_pos", pos_cnt, 0);

    // Lock with position 7, then asynchronous reset between edges.
    for (int i = 0; i < 7; i++) apply(1'b1, W'(b2g((3 + i) % NB)), 1'b0);
    check_lit("pre_reset_locked", locked, 1);
    check_lit("pre_reset_pos", pos_cnt, 7);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_lit("async_rst_outputs", {bin_out, pos_cnt, locked, err, step_up, step_dn}, 0);
    check_lit("async_rst_err_count", err_count, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    apply(1'b1, 2'd1, 1'b0);
    check_lit("post_reset_bin", bin_out, 1);
    check_lit("post_reset_first_sample", {pos_cnt, step_up, locked}, 0);

    // Randomized traffic biased towards legal up-steps so lock is reached.
    for (int n = 0; n < 2000; n++) begin
      v   = ($urandom_range(99) < 75);
      c   = ($urandom_range(99) < 3);
      sel = $urandom_range(99);
      if (sel < 55)      b = (m_prev + 1) % NB;
      else if (sel < 70) b = m_prev;
      else if (sel < 80) b = (m_prev + NB - 1) % NB;
      else               b = $urandom_range(NB - 1);
      apply(v, W'(b2g(b)), c);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_seq_decoder.md
Name: gray_seq_decoder

Overview:
- Receiving end of the gray-coded state/count bus driven by our gray counters: samples a W-bit gray code, decodes it to binary and classifies each transition.
- Tracks position, locks onto a clean incrementing sequence and flags illegal or backward transitions.
- Sits downstream of any gray-sequence source as decoder plus protocol checker.

Parameters:
W, 2, gray bus width (>=2)
LOCK_CNT, 4, consecutive legal up-steps required to enter LOCKED (1..255)
CNT_W, 8, position counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
gray_in  in  W  gray-coded input sample
in_valid  in  1  gray_in valid this cycle
clr  in  1  synchronous pulse: leave ERR / restart acquisition
bin_out  out  W  registered binary decode of last valid sample
step_up  out  1  one-cycle pulse: last sample was a +1 step
step_dn  out  1  one-cycle pulse: last sample was a -1 step
pos_cnt  out  CNT_W  running position count (wraps modulo 2^CNT_W)
locked  out  1  FSM in LOCKED
err  out  1  FSM in ERR (sticky until clr)
err_count  out  8  illegal-transition count (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): all outputs 0, state IDLE, prev_bin=0, run=0.
- Decode: bin = gray-to-binary(gray_in): bin[W-1]=g[W-1], bin[i]=bin[i+1]^g[i]. Registered: bin_out updates the cycle after in_valid (latency 1).
- Classify on in_valid: delta = (bin - prev_bin) mod 2^W. delta 0 = HOLD, 1 = UP, 2^W-1 = DN, else ILLEGAL. prev_bin <= bin on every valid sample (including ILLEGAL).
- step_up/step_dn: registered pulses, same cycle as bin_out update; at most one high; both 0 on HOLD/ILLEGAL and on first sample.
- pos_cnt: +1 on UP, -1 on DN, wraps at both ends. Loaded with 0 on first sample after IDLE.
- FSM states: IDLE, ACQ, LOCKED, ERR.
  - IDLE: first valid sample loads prev_bin, no classification, run=0 -> ACQ.
  - ACQ: UP: run+1; run reaching LOCK_CNT -> LOCKED. HOLD: run unchanged. DN: run=0, stay. ILLEGAL -> ERR.
  - LOCKED: UP/HOLD stay. DN or ILLEGAL -> ERR.
  - ERR: samples still decoded (bin_out, pos_cnt, step pulses keep updating); state held until clr -> IDLE.
- locked/err are registered state decodes, valid the cycle after the transition.
- clr in any state -> IDLE, run=0. clr with in_valid in the same cycle: clr wins, sample ignored (no prev_bin, bin_out or pos_cnt update).
- in_valid=0: no state, counter or bin_out change; step pulses low.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.

Optional Feature:
- Macro ERR_CNT_EN.
- Defined: err_count increments on every ILLEGAL sample in any state except IDLE and saturates at 255. It is cleared only by reset, not by clr.
- Not defined: err_count tied to 0 and no counter logic is built.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then gray_in 0,1,3,2,0 (W=2, LOCK_CNT=4), in_valid=1 -> bin_out 0,1,2,3,0; step_up 4 pulses; pos_cnt=4; locked=1 the cycle after the 5th sample.
- After lock, apply gray 0 then 2 (bin 0->3) -> step_dn pulse, pos_cnt decrements, err=1, locked=0. clr -> IDLE, err=0.
- In ACQ, apply gray 0 then 3 (bin 0->2, delta 2) -> ILLEGAL, err=1, no step pulse. With ERR_CNT_EN: err_count=1; 300 illegal samples -> err_count=255.
- Samples 0,1,1,1,3 with in_valid gaps -> HOLD leaves run and pos_cnt unchanged; 1->3 step_up; pos_cnt=2.
- clr and in_valid together with gray 1 -> sample ignored, state IDLE, bin_out unchanged.
- Drop rst_n between clock edges while LOCKED with pos_cnt=7 -> all outputs 0 immediately; the next sample restarts from IDLE.
